// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider.
package div_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    // Fill bit replicated across the quotient on divide by zero (all ones).
    localparam bit DBZ_QUOTIENT_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        FINISH
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus shared with the multiplier.
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic             op_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op_signed, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, op_signed, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );

endinterface

// File: rtl/seq_divider_cond_negate.sv
// Two's-complement negation when neg is set, pass-through otherwise.
module cond_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             neg,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in;
        if (neg) begin
            out = '0 - in;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned divider: restoring division on magnitudes,
// one quotient bit per cycle, then a sign-correction cycle.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state, state_nx;
    logic             accept;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg, b_mag, p;
    logic             q_neg, r_neg, dz;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             busy_r, done_r, dbz_r;

    logic             sgn_a, sgn_b, divisor_zero;
    logic [WIDTH-1:0] neg_a_in, neg_a_out, mag_b, neg_q;
    logic             neg_a_en;
    logic [WIDTH:0]   shifted;
    logic             ge;

    assign sgn_a        = bus.op_signed & bus.dividend[WIDTH-1];
    assign sgn_b        = bus.op_signed & bus.divisor[WIDTH-1];
    assign divisor_zero = (bus.divisor == '0);

    // One negator serves the dividend magnitude in IDLE and the remainder fixup later.
    assign neg_a_in = (state == IDLE) ? bus.dividend : p;
    assign neg_a_en = (state == IDLE) ? sgn_a : r_neg;

    cond_negate #(.WIDTH(WIDTH)) u_neg_a (.in(neg_a_in), .neg(neg_a_en), .out(neg_a_out));
    cond_negate #(.WIDTH(WIDTH)) u_neg_b (.in(bus.divisor), .neg(sgn_b), .out(mag_b));
    cond_negate #(.WIDTH(WIDTH)) u_neg_q (.in(a_reg), .neg(q_neg), .out(neg_q));

    // P stays below b_mag, so its top bit only exists in the shifted value.
    assign shifted = {p, a_reg[WIDTH-1]};
    assign ge      = shifted >= {1'b0, b_mag};

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = divisor_zero ? FINISH : CALC;
                end
            end
            CALC:    if (cnt == CW'(1)) state_nx = FIXUP;
            FIXUP:   state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            a_reg       <= '0;
            b_mag       <= '0;
            p           <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz          <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            done_r <= (state == FINISH);
            if (accept) begin
                // Divide by zero keeps the raw dividend so it can be returned unchanged.
                a_reg  <= divisor_zero ? bus.dividend : neg_a_out;
                b_mag  <= mag_b;
                p      <= '0;
                cnt    <= CW'(WIDTH);
                q_neg  <= sgn_a ^ sgn_b;
                r_neg  <= sgn_a;
                dz     <= divisor_zero;
                busy_r <= 1'b1;
            end
            case (state)
                CALC: begin
                    p     <= ge ? (shifted[WIDTH-1:0] - b_mag) : shifted[WIDTH-1:0];
                    a_reg <= {a_reg[WIDTH-2:0], ge};
                    cnt   <= cnt - CW'(1);
                end
                FIXUP: begin
                    quotient_r  <= neg_q;
                    remainder_r <= neg_a_out;
                    dbz_r       <= 1'b0;
                end
                FINISH: begin
                    busy_r <= 1'b0;
                    if (dz) begin
                        quotient_r  <= {WIDTH{DBZ_QUOTIENT_FILL}};
                        remainder_r <= a_reg;
                        dbz_r       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: results, latency, handshake corners.
module tb_seq_divider;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Returns #1 after the accepting edge with start already released.
    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges after the current one until done is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    vec_t vecs[11];
    int   lat;
    logic seen;

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34};
        vecs[1]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 34};
        vecs[2]  = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 34};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 34};
        vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd2,          32'h7FFFFFFF,   32'd1,          1'b0, 34};
        vecs[5]  = '{1'b0, 32'd1234,       32'd0,          32'hFFFFFFFF,   32'd1234,       1'b1, 1};
        vecs[6]  = '{1'b0, 32'd1000,       32'd10,         32'd100,        32'd0,          1'b0, 34};
        vecs[7]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0, 34};
        vecs[8]  = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 34};
        vecs[9]  = '{1'b1, 32'hFFFFFF9C,   32'd0,          32'hFFFFFFFF,   32'hFFFFFF9C,   1'b1, 1};
        vecs[10] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 34};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.op_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_quotient",  bus.quotient,  32'd0);
        check("reset_remainder", bus.remainder, 32'd0);
        check("reset_busy",      32'(bus.busy), 32'd0);
        check("reset_done",      32'(bus.done), 32'd0);
        check("reset_dbz",       32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            start_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy_after_accept", i), 32'(bus.busy), 32'd1);
            wait_done(lat);
            check($sformatf("v%0d_latency", i),   32'(lat),             32'(vecs[i].lat));
            check($sformatf("v%0d_quotient", i),  bus.quotient,         vecs[i].q);
            check($sformatf("v%0d_remainder", i), bus.remainder,        vecs[i].r);
            check($sformatf("v%0d_dbz", i),       32'(bus.div_by_zero), 32'(vecs[i].dz));
            check($sformatf("v%0d_busy_at_done", i), 32'(bus.busy),     32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_width", i), 32'(bus.done), 32'd0);
        end

        // Back-to-back: the next start is presented while done is high.
        start_op(1'b0, 32'd100, 32'd7);
        wait_done(lat);
        check("b2b_first_quotient", bus.quotient, 32'd14);
        start_op(1'b0, 32'd63, 32'd8);
        check("b2b_second_busy", 32'(bus.busy), 32'd1);
        wait_done(lat);
        check("b2b_second_latency",   32'(lat),      32'd34);
        check("b2b_second_quotient",  bus.quotient,  32'd7);
        check("b2b_second_remainder", bus.remainder, 32'd7);

        // Start pulsed at cycle 5 of a busy operation is ignored.
        start_op(1'b0, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op_signed = 1'b1;
        bus.dividend  = 32'd999;
        bus.divisor   = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
        check("ignored_start_latency",   32'(lat),      32'd29);
        check("ignored_start_quotient",  bus.quotient,  32'd14);
        check("ignored_start_remainder", bus.remainder, 32'd2);
        @(posedge clk);
        #1;
        check("ignored_start_no_second_done", 32'(bus.done), 32'd0);

        // Reset at cycle 10 of an operation aborts it without a done.
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_quotient",  bus.quotient,  32'd0);
        check("midrst_remainder", bus.remainder, 32'd0);
        check("midrst_busy",      32'(bus.busy), 32'd0);
        check("midrst_done",      32'(bus.done), 32'd0);
        check("midrst_dbz",       32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        check("midrst_no_done", 32'(seen), 32'd0);
        start_op(1'b0, 32'd50, 32'd5);
        wait_done(lat);
        check("after_rst_latency",   32'(lat),      32'd34);
        check("after_rst_quotient",  bus.quotient,  32'd10);
        check("after_rst_remainder", bus.remainder, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative 32-bit divider: the inverse operation to the sequential Booth multiplier. It shares that block's start/done handshake so the ALU controller can drive multiply and divide the same way. Signed or unsigned division is selected per operation. Internally it runs restoring division on operand magnitudes, one quotient bit per cycle, followed by a sign-correction cycle.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op_signed`  in  1  1 = two's-complement division, 0 = unsigned; captured with `start`.
- `dividend`  in  WIDTH  numerator; captured with `start`.
- `divisor`  in  WIDTH  denominator; captured with `start`.
- `quotient`  out  WIDTH  result; held until the next accepted `start`.
- `remainder`  out  WIDTH  result; held until the next accepted `start`.
- `busy`  out  1  high from the accepting edge until the edge that raises `done`.
- `done`  out  1  one-cycle pulse; results valid while high.
- `div_by_zero`  out  1  flag for the last operation; held with the results.

## Operation
- States:
  - IDLE: on `start`, go to CALC, or to FINISH if `divisor`==0.
  - CALC: runs for WIDTH cycles, then goes to FIXUP.
  - FIXUP: always goes to FINISH.
  - FINISH: always goes to IDLE.
- Accept edge (IDLE with `start`=1):
  - Load `a_mag` = |dividend| and `b_mag` = |divisor|; take absolute values only if `op_signed`.
  - Record `q_neg` = sign(dividend) XOR sign(divisor) and `r_neg` = sign(dividend); both are 0 when unsigned.
  - Clear the partial remainder P (WIDTH+1 bits).
  - Set the iteration counter to WIDTH.
- CALC, each cycle:
  - {P, A} shift left 1.
  - T = P − {0, b_mag}.
  - If T ≥ 0: P = T and A[0] = 1. Otherwise P is restored and A[0] = 0.
  - Decrement the counter.
- FIXUP: quotient = q_neg ? −A : A; remainder = r_neg ? −P[WIDTH-1:0] : P[WIDTH-1:0].
- FINISH: `done`=1 for exactly this cycle.
- Magnitude arithmetic is unsigned WIDTH bits. |0x80000000| = 0x80000000 is valid as an unsigned value.
- 0x80000000 / −1 (signed) gives quotient 0x80000000 and remainder 0, with no flag (wraps).
- Divide by zero:
  - quotient = all ones; remainder = dividend unchanged; `div_by_zero`=1.
  - No CALC cycles are run.
- `start` while `busy` is ignored; the operation in flight is unaffected.
- Reset, including in the middle of an operation:
  - State returns to IDLE.
  - `quotient`, `remainder`, `busy`, `done` and `div_by_zero` all go to 0.
  - No `done` is issued for the aborted operation.

## Timing
- Accepting edge = edge 0. `busy` rises after edge 0.
- Normal operation:
  - CALC occupies edges 1..WIDTH.
  - FIXUP writes the results at edge WIDTH+1.
  - `done` is high in the cycle after edge WIDTH+2, together with `busy`=0.
  - Latency from accept to `done` is WIDTH+2 cycles (34 at default).
- Divide by zero: results written at edge 1, `done` high after edge 1 (latency 1).
- Back-to-back: `start` may be asserted in the same cycle `done` is high. It is accepted because the state is IDLE, and a new operation begins at that edge.
- Outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `div_pkg`: state encoding constants (IDLE, CALC, FIXUP, FINISH), default `WIDTH`, divide-by-zero quotient constant.
- One sub-module, `cond_negate` (WIDTH, in, neg → out). Instantiated three times: operand magnitudes at accept, plus the quotient and remainder fixups.
- Counter width: $clog2(WIDTH+1).

## Test plan
- Unsigned 100 / 7 → quotient 14, remainder 2, `div_by_zero`=0; `done` exactly 34 cycles after accept, one cycle wide.
- Signed −100 / 7 → quotient 0xFFFFFFF2, remainder 0xFFFFFFFE. Signed 100 / −7 → quotient 0xFFFFFFF2, remainder 2.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 2 → quotient 0x7FFFFFFF, remainder 1.
- 1234 / 0 → `done` one cycle after accept; quotient 0xFFFFFFFF, remainder 1234, `div_by_zero`=1. The next normal operation clears the flag.
- `start` pulsed at cycle 5 of a busy operation with different operands → ignored; the first operation's results are returned unchanged.
- `rst` asserted at cycle 10 of an operation → all outputs 0 immediately; no `done`. A fresh 50 / 5 then gives quotient 10, remainder 0.
